// File: rtl/sdram_port_arbiter.sv
// Burst-request scheduler for the SDRAM controller: round-robin within the read and
// write groups, reads first. Optional write-starvation guard: SDRAM_ARB_WR_STARVE_EN.
module sdram_port_arbiter #(
    parameter int NUM_WR       = 2,
    parameter int NUM_RD       = 2,
    parameter int ASIZE        = 23,
    parameter int LSIZE        = 10,
    parameter int USEDW        = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      CTRL_CLK,
    input  logic                      RESET_N,
    input  logic [NUM_WR*ASIZE-1:0]   WR_BASE,
    input  logic [NUM_WR*ASIZE-1:0]   WR_MAX,
    input  logic [NUM_WR*LSIZE-1:0]   WR_LEN,
    input  logic [NUM_WR-1:0]         WR_LOAD,
    input  logic [NUM_WR*USEDW-1:0]   WR_RUSEDW,
    input  logic [NUM_RD*ASIZE-1:0]   RD_BASE,
    input  logic [NUM_RD*ASIZE-1:0]   RD_MAX,
    input  logic [NUM_RD*LSIZE-1:0]   RD_LEN,
    input  logic [NUM_RD-1:0]         RD_LOAD,
    input  logic [NUM_RD*USEDW-1:0]   RD_WUSEDW,
    output logic                      REQ_VALID,
    output logic                      REQ_WRITE,
    output logic [ASIZE-1:0]          REQ_ADDR,
    output logic [LSIZE-1:0]          REQ_LEN,
    input  logic                      REQ_ACK,
    input  logic                      XFER_DONE,
    output logic [NUM_WR-1:0]         WR_MASK,
    output logic [NUM_RD-1:0]         RD_MASK
);

    localparam int CW = (USEDW > LSIZE) ? USEDW : LSIZE;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_REQ,
        ST_BUSY,
        ST_GAP
    } state_t;

    state_t state, state_nxt;

    logic [ASIZE-1:0] wr_addr [NUM_WR];
    logic [ASIZE-1:0] rd_addr [NUM_RD];
    logic [7:0]       wr_elig, rd_elig;
    logic [2:0]       wr_ptr, rd_ptr, wr_sel, rd_sel, gnt_idx;
    logic             wr_any, rd_any, starve_force, grant_rd, grant_wr;
    logic             adv_rd, adv_wr;
    logic [3:0]       gap_cnt;
    logic [ASIZE-1:0] rd_sel_addr, wr_sel_addr;
    logic [LSIZE-1:0] rd_sel_len, wr_sel_len;

    // a and n are both small, so a single conditional subtract replaces a modulo
    function automatic logic [2:0] wrap_idx(input int a, input int n);
        return (a >= n) ? 3'(a - n) : 3'(a);
    endfunction

    function automatic logic [ASIZE-1:0] next_addr(input logic [ASIZE-1:0] addr,
                                                   input logic [LSIZE-1:0] len,
                                                   input logic [ASIZE-1:0] max,
                                                   input logic [ASIZE-1:0] base);
        logic [ASIZE:0] sum;
        sum = {1'b0, addr} + (ASIZE+1)'(len);
        return (sum < {1'b0, max}) ? sum[ASIZE-1:0] : base;
    endfunction

    always_comb begin
        rd_elig = '0;
        wr_elig = '0;
        for (int i = 0; i < NUM_RD; i++)
            rd_elig[i] = (RD_LEN[i*LSIZE +: LSIZE] != '0) && !RD_LOAD[i] &&
                         (CW'(RD_WUSEDW[i*USEDW +: USEDW]) < CW'(RD_LEN[i*LSIZE +: LSIZE]));
        for (int j = 0; j < NUM_WR; j++)
            wr_elig[j] = (WR_LEN[j*LSIZE +: LSIZE] != '0) && !WR_LOAD[j] &&
                         (CW'(WR_RUSEDW[j*USEDW +: USEDW]) >= CW'(WR_LEN[j*LSIZE +: LSIZE]));
    end

    // Scan starting at the pointer; first hit wins
    always_comb begin
        rd_any = 1'b0;
        rd_sel = '0;
        wr_any = 1'b0;
        wr_sel = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!rd_any && rd_elig[wrap_idx(int'(rd_ptr) + k, NUM_RD)]) begin
                rd_any = 1'b1;
                rd_sel = wrap_idx(int'(rd_ptr) + k, NUM_RD);
            end
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (!wr_any && wr_elig[wrap_idx(int'(wr_ptr) + k, NUM_WR)]) begin
                wr_any = 1'b1;
                wr_sel = wrap_idx(int'(wr_ptr) + k, NUM_WR);
            end
        end
    end

    always_comb begin
        rd_sel_addr = '0;
        rd_sel_len  = '0;
        wr_sel_addr = '0;
        wr_sel_len  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_sel == 3'(i)) begin
                rd_sel_addr = rd_addr[i];
                rd_sel_len  = RD_LEN[i*LSIZE +: LSIZE];
            end
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_sel == 3'(j)) begin
                wr_sel_addr = wr_addr[j];
                wr_sel_len  = WR_LEN[j*LSIZE +: LSIZE];
            end
        end
    end

`ifdef SDRAM_ARB_WR_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    assign starve_force = wr_any && (starve_cnt == SW'(STARVE_LIMIT));

    always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
        if (!RESET_N)
            starve_cnt <= '0;
        else if (state == ST_IDLE && grant_wr)
            starve_cnt <= '0;
        else if (state == ST_IDLE && grant_rd && wr_any)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign starve_force = 1'b0;
`endif

    assign grant_wr = wr_any && (!rd_any || starve_force);
    assign grant_rd = rd_any && !starve_force;
    assign adv_rd   = (state == ST_BUSY) && XFER_DONE && !REQ_WRITE;
    assign adv_wr   = (state == ST_BUSY) && XFER_DONE && REQ_WRITE;

    always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: state_nxt = ST_IDLE;
            ST_IDLE: if (grant_rd || grant_wr) state_nxt = ST_REQ;
            ST_REQ:  if (REQ_ACK)              state_nxt = ST_BUSY;
            ST_BUSY: if (XFER_DONE)            state_nxt = ST_GAP;
            ST_GAP:  if (gap_cnt == '0)        state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // LOAD always wins over the post-transfer advance
    always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_RD; i++) rd_addr[i] <= '0;
            for (int j = 0; j < NUM_WR; j++) wr_addr[j] <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (state == ST_INIT || RD_LOAD[i])
                    rd_addr[i] <= RD_BASE[i*ASIZE +: ASIZE];
                else if (adv_rd && gnt_idx == 3'(i))
                    rd_addr[i] <= next_addr(rd_addr[i], RD_LEN[i*LSIZE +: LSIZE],
                                            RD_MAX[i*ASIZE +: ASIZE], RD_BASE[i*ASIZE +: ASIZE]);
            end
            for (int j = 0; j < NUM_WR; j++) begin
                if (state == ST_INIT || WR_LOAD[j])
                    wr_addr[j] <= WR_BASE[j*ASIZE +: ASIZE];
                else if (adv_wr && gnt_idx == 3'(j))
                    wr_addr[j] <= next_addr(wr_addr[j], WR_LEN[j*LSIZE +: LSIZE],
                                            WR_MAX[j*ASIZE +: ASIZE], WR_BASE[j*ASIZE +: ASIZE]);
            end
        end
    end

    always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            REQ_VALID <= 1'b0;
            REQ_WRITE <= 1'b0;
            REQ_ADDR  <= '0;
            REQ_LEN   <= '0;
            WR_MASK   <= '0;
            RD_MASK   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            gnt_idx   <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_rd) begin
                        REQ_VALID <= 1'b1;
                        REQ_WRITE <= 1'b0;
                        REQ_ADDR  <= rd_sel_addr;
                        REQ_LEN   <= rd_sel_len;
                        RD_MASK   <= NUM_RD'(1) << rd_sel;
                        gnt_idx   <= rd_sel;
                        rd_ptr    <= wrap_idx(int'(rd_sel) + 1, NUM_RD);
                    end else if (grant_wr) begin
                        REQ_VALID <= 1'b1;
                        REQ_WRITE <= 1'b1;
                        REQ_ADDR  <= wr_sel_addr;
                        REQ_LEN   <= wr_sel_len;
                        WR_MASK   <= NUM_WR'(1) << wr_sel;
                        gnt_idx   <= wr_sel;
                        wr_ptr    <= wrap_idx(int'(wr_sel) + 1, NUM_WR);
                    end
                end
                ST_REQ: if (REQ_ACK) REQ_VALID <= 1'b0;
                ST_BUSY: begin
                    if (XFER_DONE) begin
                        WR_MASK <= '0;
                        RD_MASK <= '0;
                        gap_cnt <= 4'(GAP_CYCLES);
                    end
                end
                ST_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
